qpi_flash_responder: RTL

Synthesizable QPI flash target: the device end of the `qpi_flash` controller's bus. It oversamples `flash_nCE`/`flash_SCK` with the system clock, decodes the SPI-mode QPI-enable command and the QPI fast-read command, and fetches bytes from a byte-wide memory port. It streams those bytes back as nybbles. It lets a board or simulation stand in for a real flash chip behind the controller.

---
 rtl/qpi_flash_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/qpi_flash_responder.sv
// QPI flash target: oversamples the controller's nCE/SCK/IO, decodes the SPI
// QPI-enable and QPI fast-read commands, and streams bytes from a memory port.
module qpi_flash_responder #(
    parameter int DUMMY_CLOCKS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flash_nCE,
    input  logic        flash_SCK,
    input  logic [3:0]  flash_IO_in,
    output logic [3:0]  flash_IO_out,
    output logic        flash_IO_oe,
    output logic [23:0] mem_addr,
    output logic        mem_read,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        qpi_mode
);
    typedef enum logic [2:0] {
        IDLE, SPI_CMD, QPI_CMD, ADDR, DUMMY, DATA, IGNORE
    } state_t;

    localparam logic [5:0] SYNC_RST   = 6'b10_0000;
    localparam logic [7:0] DUMMY_LAST = (DUMMY_CLOCKS > 0) ? 8'(DUMMY_CLOCKS - 1) : 8'd0;

    state_t      state_reg, state_next;
    logic [5:0]  sync1_reg, sync2_reg;
    logic        sck_prev_reg;
    logic [7:0]  cnt_reg;
    logic [19:0] shift_reg;
    logic [3:0]  cur_low_reg;
    logic [7:0]  next_byte_reg;
    logic        next_valid_reg;
    logic        pending_reg;
    logic        discard_reg;
    logic        want_reg;
    logic        nyb_low_reg;

    logic        nce_s, sck_s;
    logic [3:0]  io_s;
    logic        sck_rise, sck_fall;
    logic [7:0]  spi_byte, qpi_byte, byte_in;
    logic [23:0] addr_full;
    logic        ack_take, req_free, byte_avail;

    // nCE resets high so a reset never looks like the start of a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg    <= SYNC_RST;
            sync2_reg    <= SYNC_RST;
            sck_prev_reg <= 1'b0;
        end else begin
            sync1_reg    <= {flash_nCE, flash_SCK, flash_IO_in};
            sync2_reg    <= sync1_reg;
            sck_prev_reg <= sync2_reg[4];
        end
    end

    assign nce_s     = sync2_reg[5];
    assign sck_s     = sync2_reg[4];
    assign io_s      = sync2_reg[3:0];
    assign sck_rise  = sck_s & ~sck_prev_reg;
    assign sck_fall  = ~sck_s & sck_prev_reg;
    assign spi_byte  = {shift_reg[6:0], io_s[0]};
    assign qpi_byte  = {shift_reg[3:0], io_s};
    assign addr_full = {shift_reg[19:0], io_s};

    assign ack_take   = mem_ack && pending_reg && (state_reg == DATA || state_reg == DUMMY);
    assign req_free   = !pending_reg || ack_take;
    assign byte_avail = next_valid_reg || (ack_take && !discard_reg);
    assign byte_in    = next_valid_reg ? next_byte_reg : mem_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (nce_s) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = qpi_mode ? QPI_CMD : SPI_CMD;
                SPI_CMD: if (sck_rise && cnt_reg == 8'd7) state_next = IGNORE;
                QPI_CMD: if (sck_rise && cnt_reg == 8'd1)
                             state_next = (qpi_byte == 8'hEB) ? ADDR : IGNORE;
                ADDR:    if (sck_rise && cnt_reg == 8'd5)
                             state_next = (DUMMY_CLOCKS == 0) ? DATA : DUMMY;
                DUMMY:   if (sck_rise && cnt_reg == DUMMY_LAST) state_next = DATA;
                DATA:    state_next = DATA;
                IGNORE:  state_next = IGNORE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_IO_out   <= 4'h0;
            flash_IO_oe    <= 1'b0;
            mem_addr       <= 24'h0;
            mem_read       <= 1'b0;
            qpi_mode       <= 1'b0;
            cnt_reg        <= 8'd0;
            shift_reg      <= 20'h0;
            cur_low_reg    <= 4'h0;
            next_byte_reg  <= 8'h0;
            next_valid_reg <= 1'b0;
            pending_reg    <= 1'b0;
            discard_reg    <= 1'b0;
            want_reg       <= 1'b0;
            nyb_low_reg    <= 1'b0;
        end else begin
            mem_read <= 1'b0;
            if (nce_s) begin
                flash_IO_oe    <= 1'b0;
                cnt_reg        <= 8'd0;
                next_valid_reg <= 1'b0;
                pending_reg    <= 1'b0;
                discard_reg    <= 1'b0;
                want_reg       <= 1'b0;
                nyb_low_reg    <= 1'b0;
            end else begin
                if (sck_rise && (state_reg == SPI_CMD || state_reg == QPI_CMD ||
                                 state_reg == ADDR || state_reg == DUMMY)) begin
                    cnt_reg   <= (state_next != state_reg) ? 8'd0 : cnt_reg + 8'd1;
                    shift_reg <= (state_reg == SPI_CMD) ? {shift_reg[18:0], io_s[0]}
                                                        : {shift_reg[15:0], io_s};
                end
                if (state_reg == SPI_CMD && sck_rise && cnt_reg == 8'd7 && spi_byte == 8'h38)
                    qpi_mode <= 1'b1;
                if (state_reg == QPI_CMD && sck_rise && cnt_reg == 8'd1 && qpi_byte == 8'hFF)
                    qpi_mode <= 1'b0;

                if (state_reg == ADDR && state_next != ADDR) begin
                    mem_addr       <= addr_full;
                    mem_read       <= 1'b1;
                    pending_reg    <= 1'b1;
                    discard_reg    <= 1'b0;
                    next_valid_reg <= 1'b0;
                    want_reg       <= 1'b0;
                    nyb_low_reg    <= 1'b0;
                end

                // an ack for a byte already replaced by 0xFF only retires the request
                if (ack_take) begin
                    pending_reg <= 1'b0;
                    discard_reg <= 1'b0;
                    if (!discard_reg) begin
                        next_byte_reg  <= mem_data;
                        next_valid_reg <= 1'b1;
                    end
                end

                if (state_reg == DATA && sck_fall) begin
                    flash_IO_oe <= 1'b1;
                    nyb_low_reg <= ~nyb_low_reg;
                    if (!nyb_low_reg) begin
                        next_valid_reg <= 1'b0;
                        if (byte_avail) begin
                            cur_low_reg  <= byte_in[3:0];
                            flash_IO_out <= byte_in[7:4];
                        end else begin
                            cur_low_reg  <= 4'hF;
                            flash_IO_out <= 4'hF;
                            if (pending_reg && !ack_take)
                                discard_reg <= 1'b1;
                        end
                    end else begin
                        flash_IO_out <= cur_low_reg;
                        mem_addr     <= mem_addr + 24'd1;
                        if (req_free) begin
                            mem_read    <= 1'b1;
                            pending_reg <= 1'b1;
                        end else begin
                            want_reg <= 1'b1;
                        end
                    end
                end else if (state_reg == DATA && want_reg && req_free) begin
                    // prefetch held back until the stale request retires
                    mem_read    <= 1'b1;
                    pending_reg <= 1'b1;
                    want_reg    <= 1'b0;
                end
            end
        end
    end
endmodule
